// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter on the MEM-stage data bus.
// Byte stores to TX_ADDR queue into a small FIFO; STATUS_ADDR returns {overflow, full, empty, busy}.
module uart_tx_port #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] TX_ADDR      = 32'h1001_0024,
   parameter logic [31:0] STATUS_ADDR  = 32'h1001_0028
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  Hit,
   output logic                  tx,
   output logic                  TxBusy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

   txState_t         state, stateNext;
   logic [CNT_W-1:0] baudCnt, baudNext;
   logic [2:0]       bitIdx, bitNext;
   logic [7:0]       shiftReg, shiftNext;
   logic             txNext;
   logic             popReq;
   logic             baudEnd;

   logic [7:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [PTR_W:0]   fifoCount;
   logic             fifoEmpty, fifoFull;
   logic             pushReq, pushAccept, ovfEvent, statusRd;
   logic             overflow;
   logic             unusedWdata;

   assign unusedWdata = ^WriteData[DATA_WIDTH-1:8];

   assign Hit        = (Address == TX_ADDR) || (Address == STATUS_ADDR);
   assign pushReq    = MemWrite && (Address == TX_ADDR);
   assign statusRd   = MemRead && (Address == STATUS_ADDR);
   assign fifoEmpty  = (fifoCount == '0);
   assign fifoFull   = (fifoCount == FIFO_FULL);
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign pushAccept = pushReq && (!fifoFull || popReq);
   assign ovfEvent   = pushReq && fifoFull && !popReq;
   assign baudEnd    = (baudCnt == BAUD_LAST);
   assign TxBusy     = (state != IDLE);

   always_comb begin
      ReadData = '0;
      if (statusRd) ReadData[3:0] = {overflow, fifoFull, fifoEmpty, TxBusy};
   end

   always_comb begin
      stateNext = state;
      baudNext  = baudCnt;
      bitNext   = bitIdx;
      shiftNext = shiftReg;
      popReq    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               popReq    = 1'b1;
               shiftNext = fifoMem[rdPtr];
               baudNext  = '0;
               stateNext = START;
            end
         end
         START: begin
            if (baudEnd) begin
               baudNext  = '0;
               bitNext   = '0;
               stateNext = DATA;
            end else begin
               baudNext = baudCnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (baudEnd) begin
               baudNext = '0;
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
               end else begin
                  bitNext   = bitIdx + 3'd1;
                  shiftNext = {1'b0, shiftReg[7:1]};
               end
            end else begin
               baudNext = baudCnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (baudEnd) begin
               baudNext = '0;
               // Chain straight into the next start bit when more data is waiting.
               if (!fifoEmpty) begin
                  popReq    = 1'b1;
                  shiftNext = fifoMem[rdPtr];
                  stateNext = START;
               end else begin
                  stateNext = IDLE;
               end
            end else begin
               baudNext = baudCnt + CNT_W'(1);
            end
         end
      endcase
   end

   // The line level is registered from the state being entered, so it changes with the state.
   always_comb begin
      txNext = 1'b1;
      unique case (stateNext)
         IDLE:  txNext = 1'b1;
         START: txNext = 1'b0;
         DATA:  txNext = shiftNext[0];
         STOP:  txNext = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         baudCnt   <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         tx        <= 1'b1;
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         overflow  <= 1'b0;
      end else begin
         state    <= stateNext;
         baudCnt  <= baudNext;
         bitIdx   <= bitNext;
         shiftReg <= shiftNext;
         tx       <= txNext;
         if (pushAccept) wrPtr <= wrPtr + PTR_W'(1);
         if (popReq)     rdPtr <= rdPtr + PTR_W'(1);
         unique case ({pushAccept, popReq})
            2'b10:   fifoCount <= fifoCount + (PTR_W + 1)'(1);
            2'b01:   fifoCount <= fifoCount - (PTR_W + 1)'(1);
            default: fifoCount <= fifoCount;
         endcase
         if (ovfEvent)      overflow <= 1'b1;
         else if (statusRd) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (pushAccept) fifoMem[wrPtr] <= WriteData[7:0];
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: frame shape, back-to-back, overflow, async reset and decode.
module tb_uart_tx_port;

   localparam logic [31:0] TX_ADDR     = 32'h1001_0024;
   localparam logic [31:0] STATUS_ADDR = 32'h1001_0028;
   localparam int          LOG_N       = 2048;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;
   logic        tx;
   logic        TxBusy;

   int   vecCount = 0;
   int   errCount = 0;
   int   posCnt   = 0;
   logic txLog   [LOG_N];
   logic busyLog [LOG_N];

   uart_tx_port #(
      .DATA_WIDTH(32), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
      .TX_ADDR(TX_ADDR), .STATUS_ADDR(STATUS_ADDR)
   ) dut (
      .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
      .Hit(Hit), .tx(tx), .TxBusy(TxBusy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle c is the interval after the c-th rising edge; its registered outputs are logged mid-cycle.
   always @(posedge clk) posCnt <= posCnt + 1;
   always @(negedge clk) begin
      if (posCnt < LOG_N) begin
         txLog[posCnt]   <= tx;
         busyLog[posCnt] <= TxBusy;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitUntil(input int cyc);
      while (posCnt < cyc) tick();
   endtask

   task automatic storeByte(input logic [31:0] addr, input logic [7:0] b);
      Address   = addr;
      WriteData = {24'hDEAD_BE, b};
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
      Address   = 32'h0;
   endtask

   task automatic statusRead(input string tag, input logic [31:0] exp);
      Address = STATUS_ADDR;
      MemRead = 1'b1;
      #1;
      checkVal(tag, ReadData, exp);
      tick();
      MemRead = 1'b0;
      Address = 32'h0;
   endtask

   // Compares 40 logged cycles from st against an 8N1 frame of b at 4 clocks per bit.
   task automatic checkFrame(input string tag, input int st, input logic [7:0] b);
      logic [39:0] got, exp;
      int busyN;
      busyN = 0;
      for (int i = 0; i < 40; i++) begin
         got[i] = txLog[st + i];
         if (i < 4)       exp[i] = 1'b0;
         else if (i < 36) exp[i] = b[(i - 4) / 4];
         else             exp[i] = 1'b1;
         busyN += int'(busyLog[st + i]);
      end
      checkVal({tag, "_wave"}, got, exp);
      checkVal({tag, "_busy"}, busyN, 40);
   endtask

   task automatic checkQuiet(input string tag, input int st, input int n);
      int active;
      active = 0;
      for (int i = 0; i < n; i++) active += int'(!txLog[st + i]) + int'(busyLog[st + i]);
      checkVal(tag, active, 0);
   endtask

   initial begin
      int s;
      int busyN;
      reset     = 1'b0;
      Address   = STATUS_ADDR;
      WriteData = 32'h0;
      MemWrite  = 1'b0;
      MemRead   = 1'b1;

      // Reset values
      tick();
      tick();
      checkVal("rst_tx", tx, 1);
      checkVal("rst_busy", TxBusy, 0);
      checkVal("rst_status", ReadData, 32'h2);
      checkVal("rst_hit", Hit, 1);
      reset = 1'b1;
      tick();
      MemRead = 1'b0;
      Address = 32'h0;
      tick();

      // Single frame
      s = posCnt;
      storeByte(TX_ADDR, 8'hA5);
      waitUntil(s + 50);
      checkVal("a5_pre_tx", txLog[s + 1], 1);
      checkFrame("a5", s + 2, 8'hA5);
      busyN = 0;
      for (int i = 0; i < 50; i++) busyN += int'(busyLog[s + i]);
      checkVal("a5_busy_total", busyN, 40);
      checkVal("a5_post_busy", busyLog[s + 42], 0);

      // Back-to-back
      s = posCnt;
      storeByte(TX_ADDR, 8'h01);
      storeByte(TX_ADDR, 8'h02);
      waitUntil(s + 95);
      checkFrame("b2b_01", s + 2, 8'h01);
      checkFrame("b2b_02", s + 42, 8'h02);
      busyN = 0;
      for (int i = 0; i < 95; i++) busyN += int'(busyLog[s + i]);
      checkVal("b2b_busy_total", busyN, 80);
      statusRead("b2b_status", 32'h2);

      // Overflow, then push+pop while full at the end of the first frame
      tick();
      s = posCnt;
      for (int i = 0; i < 6; i++) storeByte(TX_ADDR, 8'(8'h11 + i));
      statusRead("ovf_status_set", 32'hD);
      statusRead("ovf_status_clr", 32'h5);
      waitUntil(s + 41);
      storeByte(TX_ADDR, 8'h17);
      statusRead("full_pushpop_status", 32'h5);
      waitUntil(s + 250);
      checkFrame("ovf_11", s + 2,   8'h11);
      checkFrame("ovf_12", s + 42,  8'h12);
      checkFrame("ovf_13", s + 82,  8'h13);
      checkFrame("ovf_14", s + 122, 8'h14);
      checkFrame("ovf_15", s + 162, 8'h15);
      checkFrame("ovf_17", s + 202, 8'h17);
      checkVal("ovf_post_busy", busyLog[s + 242], 0);
      statusRead("ovf_final_status", 32'h2);

      // Reset mid-frame, with a second byte queued
      s = posCnt;
      storeByte(TX_ADDR, 8'hFF);
      storeByte(TX_ADDR, 8'h81);
      waitUntil(s + 10);
      #2;
      reset = 1'b0;
      #1;
      checkVal("midrst_tx", tx, 1);
      checkVal("midrst_busy", TxBusy, 0);
      Address = STATUS_ADDR;
      MemRead = 1'b1;
      #1;
      checkVal("midrst_status", ReadData, 32'h2);
      tick();
      reset   = 1'b1;
      MemRead = 1'b0;
      Address = 32'h0;
      s = posCnt;
      waitUntil(s + 12);
      checkQuiet("midrst_discard", s + 1, 10);
      s = posCnt;
      storeByte(TX_ADDR, 8'h3C);
      waitUntil(s + 45);
      checkFrame("post_rst_3c", s + 2, 8'h3C);
      checkVal("post_rst_busy", busyLog[s + 42], 0);

      // Address decode
      Address   = 32'h1001_0020;
      WriteData = 32'h55;
      MemWrite  = 1'b1;
      MemRead   = 1'b1;
      #1;
      checkVal("dec_0020_hit", Hit, 0);
      checkVal("dec_0020_rd", ReadData, 0);
      s = posCnt;
      tick();
      Address = 32'h0000_0000;
      #1;
      checkVal("dec_zero_hit", Hit, 0);
      checkVal("dec_zero_rd", ReadData, 0);
      tick();
      Address = STATUS_ADDR;
      MemRead = 1'b0;
      #1;
      checkVal("dec_stat_store_hit", Hit, 1);
      checkVal("dec_stat_noread_rd", ReadData, 0);
      tick();
      Address  = TX_ADDR;
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      #1;
      checkVal("dec_tx_load_hit", Hit, 1);
      checkVal("dec_tx_load_rd", ReadData, 0);
      tick();
      MemRead = 1'b0;
      Address = 32'h0;
      waitUntil(s + 14);
      checkQuiet("dec_idle", s + 1, 12);
      statusRead("dec_status", 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped serial transmit peripheral on the MIPS core's MEM-stage data bus, alongside the data memory. It decodes the same address, write-data and strobe signals that feed the data memory, accepts byte writes into a small FIFO, and serialises them as 8N1 UART frames. A status word is readable through the same bus and returned on the load path.

## Interface
Parameters:
- DATA_WIDTH, 32, bus data width.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥2.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2.
- TX_ADDR, 32'h1001_0024, transmit-data register address.
- STATUS_ADDR, 32'h1001_0028, status register address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  MEM-stage byte address (the ALU result).
- WriteData  input  DATA_WIDTH  store data; only bits [7:0] are used.
- MemWrite  input  1  store strobe.
- MemRead  input  1  load strobe.
- ReadData  output  DATA_WIDTH  status word while a status read is active, otherwise 0.
- Hit  output  1  combinational; high when Address equals TX_ADDR or STATUS_ADDR.
- tx  output  1  registered serial line, idle high.
- TxBusy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Push: when MemWrite=1 and Address=TX_ADDR, WriteData[7:0] is written into the FIFO at the rising edge.
  - If the FIFO is full, the byte is dropped and the sticky overflow flag is set.
  - A push and a pop on the same edge are both accepted, including when the FIFO is full; no overflow is flagged.
- Stores to STATUS_ADDR are ignored. Stores to any other address are ignored.
- Status read: when MemRead=1 and Address=STATUS_ADDR, ReadData is combinational: {0…, overflow, full, empty, busy} in bits [3:0]; all upper bits are 0.
  - The overflow flag clears on the edge that ends a status-read cycle.
  - A new overflow event on that same edge takes priority, so the flag stays set.
- ReadData is 0 in every other case.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The occupancy count is one bit wider than the pointers.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, sent LSB first. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if the FIFO is non-empty, pop and go straight to START (no idle gap);
    - otherwise go to IDLE.
- The baud counter is $clog2(CLKS_PER_BIT) bits. It counts 0…CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Reset values: tx=1, TxBusy=0, FSM=IDLE, FIFO empty (count=0, pointers=0), overflow=0, shift register=0, baud counter=0. ReadData and Hit depend only on their inputs.
- Reset mid-frame: tx returns to 1 asynchronously, FIFO contents are discarded, and the FSM goes to IDLE. After reset releases, operation resumes normally.

## Timing
- Write latency: a store presented in cycle 0 is counted at the end of cycle 0. The FSM pops at the end of cycle 1, and tx is low from the start of cycle 2.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames are contiguous: the next start bit immediately follows the stop bit.
- Capacity: FIFO_DEPTH bytes are queued plus 1 byte in flight. Full means count=FIFO_DEPTH.
- TxBusy rises on the same edge as the IDLE→START transition. It falls on the edge of the STOP→IDLE transition.
- Status flags reflect the registered state of the current cycle; a push in cycle N is visible in cycle N+1.

## Test plan
Tests 1–5 use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. **Reset values:** assert reset, then read status. Expect tx=1, TxBusy=0, ReadData=0x2 (empty) and Hit=1.
2. **Single frame:** store 0xA5 to TX_ADDR. tx is low from cycle 2 for 4 cycles, then carries data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then is high for 4 cycles. TxBusy is high for exactly 40 cycles.
3. **Back-to-back:** store 0x01 then 0x02 in consecutive cycles. Expect two contiguous frames with no idle gap, 80 busy cycles, and final status 0x2.
4. **Overflow:** store 0x11…0x16 in 6 consecutive cycles.
   - 0x11–0x15 are transmitted in order and 0x16 is dropped.
   - A status read during transmission shows bit3=1 and full=1 (value 0xD).
   - The next status read shows bit3=0.
5. **Reset mid-frame:** pulse reset during DATA of 0xFF. tx goes to 1 without waiting for a clock and status reads 0x2. Then store 0x3C and confirm one correct frame.
6. **Decode:** store and load at 0x1001_0020 and other addresses. Expect Hit=0, ReadData=0, the FIFO unchanged and tx idle.
